// File: rtl/adder_stream_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared pipelined AXI4-Stream adder.
// One registered output stage carries each beat together with the winner's add constant.
module adder_stream_arbiter #(
  parameter int C_NUM_REQ          = 4,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_AXIS_TID_WIDTH   = 3
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic                                        ctrl_enable,
  input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]      ctrl_constant,
  input  logic [C_NUM_REQ-1:0]                        s_axis_tvalid,
  output logic [C_NUM_REQ-1:0]                        s_axis_tready,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_NUM_REQ-1:0]                        s_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                        m_axis_tlast,
  output logic [C_AXIS_TID_WIDTH-1:0]                 m_axis_tid,
  output logic [C_ADDER_BIT_WIDTH-1:0]                m_constant,
  output logic                                        status_busy,
  output logic [C_AXIS_TID_WIDTH-1:0]                 status_grant
);

  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int CW = C_ADDER_BIT_WIDTH;
  localparam int SW = $clog2(C_NUM_REQ);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_grant;
  logic [SW-1:0]   r_last_grant;
  logic [CW-1:0]   r_const_lat;

  logic            r_m_tvalid;
  logic [DW-1:0]   r_m_tdata;
  logic [KW-1:0]   r_m_tkeep;
  logic            r_m_tlast;
  logic [SW-1:0]   r_m_tid;
  logic [CW-1:0]   r_m_constant;

  logic            w_found;
  logic [SW-1:0]   w_winner;
  logic [SW:0]     w_cand;
  logic            w_arb;
  logic            w_ready;
  logic            w_xfer;
  logic [DW-1:0]   w_sel_tdata;
  logic [KW-1:0]   w_sel_tkeep;
  logic            w_sel_tlast;

  // Round-robin search starting one past the last completed grant, wrapping at C_NUM_REQ.
  // NOTE: every signal written here is given a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_cand   = '0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      w_cand = {1'b0, r_last_grant} + (SW+1)'(k);
      if (w_cand >= (SW+1)'(C_NUM_REQ))
        w_cand = w_cand - (SW+1)'(C_NUM_REQ);
      if (!w_found && s_axis_tvalid[w_cand[SW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[SW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_tdata = s_axis_tdata[int'(r_grant)*DW +: DW];
    w_sel_tkeep = s_axis_tkeep[int'(r_grant)*KW +: KW];
    w_sel_tlast = s_axis_tlast[r_grant];
  end

  // Ready depends only on output-register occupancy, never on the requester's valid.
  assign w_ready = (r_state == ST_LOCKED) && (!r_m_tvalid || m_axis_tready);
  assign w_xfer  = w_ready && s_axis_tvalid[r_grant];

  always_comb begin
    s_axis_tready = '0;
    if (w_ready)
      s_axis_tready = C_NUM_REQ'(1) << r_grant;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctrl_enable && w_found) begin
          w_state_nxt = ST_LOCKED;
          w_arb       = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_xfer && w_sel_tlast)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= SW'(C_NUM_REQ - 1);
      r_const_lat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arb) begin
        r_grant     <= w_winner;
        r_const_lat <= ctrl_constant[int'(w_winner)*CW +: CW];
      end
      if (w_xfer && w_sel_tlast)
        r_last_grant <= r_grant;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_m_tvalid   <= 1'b0;
      r_m_tdata    <= '0;
      r_m_tkeep    <= '0;
      r_m_tlast    <= 1'b0;
      r_m_tid      <= '0;
      r_m_constant <= '0;
    end else if (w_xfer) begin
      r_m_tvalid   <= 1'b1;
      r_m_tdata    <= w_sel_tdata;
      r_m_tkeep    <= w_sel_tkeep;
      r_m_tlast    <= w_sel_tlast;
      r_m_tid      <= r_grant;
      r_m_constant <= r_const_lat;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tid    = C_AXIS_TID_WIDTH'(r_m_tid);
  assign m_constant    = r_m_constant;
  assign status_busy   = (r_state == ST_LOCKED);
  assign status_grant  = C_AXIS_TID_WIDTH'(r_grant);

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// Self-checking bench for adder_stream_arbiter: hand-derived grant-order table, directed
// corner sequences and randomized traffic against a transaction-level reference model.
module tb_adder_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int CW = 32;
  localparam int TW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int unsigned   tid;
    logic [DW-1:0] data;
    logic          last;
    logic [CW-1:0] cst;
    int unsigned   cyc;
  } obs_t;

  typedef struct packed {
    logic [N-1:0] mask;
    logic [2:0]   n;
    logic [7:0]   order;
  } vec_t;

  logic                aclk = 1'b0;
  logic                areset;
  logic                ctrl_enable;
  logic [N*CW-1:0]     ctrl_constant;
  logic [N-1:0]        s_axis_tvalid;
  logic [N-1:0]        s_axis_tready;
  logic [N*DW-1:0]     s_axis_tdata;
  logic [N*KW-1:0]     s_axis_tkeep;
  logic [N-1:0]        s_axis_tlast;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [DW-1:0]       m_axis_tdata;
  logic [KW-1:0]       m_axis_tkeep;
  logic                m_axis_tlast;
  logic [TW-1:0]       m_axis_tid;
  logic [CW-1:0]       m_constant;
  logic                status_busy;
  logic [TW-1:0]       status_grant;

  adder_stream_arbiter #(
    .C_NUM_REQ          (N),
    .C_AXIS_TDATA_WIDTH (DW),
    .C_ADDER_BIT_WIDTH  (CW),
    .C_AXIS_TID_WIDTH   (TW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .ctrl_enable   (ctrl_enable),
    .ctrl_constant (ctrl_constant),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_constant    (m_constant),
    .status_busy   (status_busy),
    .status_grant  (status_grant)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  beat_t        src_q[N][$];
  logic [N-1:0] gate;
  obs_t         obs_q[$];
  int unsigned  n_pass  = 0;
  int unsigned  n_total = 0;
  int unsigned  cyc     = 0;
  vec_t         vecs[6];

  // Reference model: arbitration state and the single output-register slot.
  bit            mdl_idle;
  logic [1:0]    mdl_g, mdl_last, mdl_sgrant, mdl_tid;
  logic [CW-1:0] mdl_const, mdl_ocst;
  bit            mdl_mv;
  beat_t         mdl_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // With N=4, two-bit addition wraps modulo N on its own.
  function automatic logic [1:0] rr_pick(input logic [N-1:0] v, input logic [1:0] last);
    logic [1:0] idx;
    for (int k = 1; k <= N; k++) begin
      idx = last + 2'(k);
      if (v[idx]) return idx;
    end
    return last;
  endfunction

  task automatic model_reset();
    mdl_idle   = 1'b1;
    mdl_g      = '0;
    mdl_last   = 2'(N - 1);
    mdl_sgrant = '0;
    mdl_tid    = '0;
    mdl_const  = '0;
    mdl_ocst   = '0;
    mdl_mv     = 1'b0;
    mdl_out    = '0;
  endtask

  task automatic set_const(input int r, input logic [CW-1:0] v);
    ctrl_constant[r*CW +: CW] = v;
  endtask

  task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + DW'(i);
      b.keep = KW'($urandom);
      b.last = (i == len - 1);
      src_q[r].push_back(b);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (src_q[r].size() > 0 && gate[r]) begin
        s_axis_tvalid[r]          = 1'b1;
        s_axis_tdata[r*DW +: DW]  = src_q[r][0].data;
        s_axis_tkeep[r*KW +: KW]  = src_q[r][0].keep;
        s_axis_tlast[r]           = src_q[r][0].last;
      end else begin
        s_axis_tvalid[r]          = 1'b0;
        s_axis_tdata[r*DW +: DW]  = '0;
        s_axis_tkeep[r*KW +: KW]  = '0;
        s_axis_tlast[r]           = 1'b0;
      end
    end
  endtask

  // One clock: drive at negedge, check ready, advance model across posedge, compare at next negedge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    bit           xfer;
    beat_t        b;
    obs_t         o;
    drive();
    #1;
    exp_rdy = '0;
    if (!mdl_idle && (!mdl_mv || m_axis_tready)) exp_rdy[mdl_g] = 1'b1;
    check("s_axis_tready", 64'(s_axis_tready), 64'(exp_rdy));
    if (m_axis_tvalid && m_axis_tready) begin
      o.tid  = int'(m_axis_tid);
      o.data = m_axis_tdata;
      o.last = m_axis_tlast;
      o.cst  = m_constant;
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
    xfer = !mdl_idle && s_axis_tvalid[mdl_g] && exp_rdy[mdl_g];
    b = '0;
    if (xfer) b = src_q[mdl_g].pop_front();
    @(posedge aclk);
    if (mdl_idle && ctrl_enable && (|s_axis_tvalid)) begin
      mdl_g      = rr_pick(s_axis_tvalid, mdl_last);
      mdl_idle   = 1'b0;
      mdl_const  = ctrl_constant[mdl_g*CW +: CW];
      mdl_sgrant = mdl_g;
    end
    if (xfer) begin
      mdl_mv   = 1'b1;
      mdl_out  = b;
      mdl_tid  = mdl_g;
      mdl_ocst = mdl_const;
      if (b.last) begin
        mdl_last = mdl_g;
        mdl_idle = 1'b1;
      end
    end else if (m_axis_tready) begin
      mdl_mv = 1'b0;
    end
    @(negedge aclk);
    cyc++;
    check("m_axis_tvalid", 64'(m_axis_tvalid), 64'(mdl_mv));
    check("status_busy", 64'(status_busy), 64'(!mdl_idle));
    check("status_grant", 64'(status_grant), 64'(mdl_sgrant));
    if (mdl_mv) begin
      check("m_axis_tdata", 64'(m_axis_tdata), 64'(mdl_out.data));
      check("m_axis_tkeep", 64'(m_axis_tkeep), 64'(mdl_out.keep));
      check("m_axis_tlast", 64'(m_axis_tlast), 64'(mdl_out.last));
      check("m_axis_tid", 64'(m_axis_tid), 64'(mdl_tid));
      check("m_constant", 64'(m_constant), 64'(mdl_ocst));
    end
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    ctrl_enable   = 1'b1;
    ctrl_constant = '0;
    m_axis_tready = 1'b1;
    gate          = '1;
    for (int r = 0; r < N; r++) src_q[r].delete();
    obs_q.delete();
    drive();
    model_reset();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic run_until_obs(input int n, input int budget, input string name);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({name, " beats seen"}, 64'(obs_q.size() >= n), 64'd1);
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    bit busy;
    ctrl_enable   = 1'b1;
    m_axis_tready = 1'b1;
    gate          = '1;
    busy = 1'b1;
    while (busy && k < budget) begin
      busy = !mdl_idle || mdl_mv;
      for (int r = 0; r < N; r++) if (src_q[r].size() > 0) busy = 1'b1;
      if (busy) tick();
      k++;
    end
    check({name, " drained"}, 64'(m_axis_tvalid || status_busy), 64'd0);
  endtask

  initial begin
    // Grant order from a chain of one-beat bursts; last_grant carries over between rows.
    vecs[0] = '{mask: 4'b0010, n: 3'd1, order: 8'b00_00_00_01};
    vecs[1] = '{mask: 4'b1111, n: 3'd4, order: 8'b01_00_11_10};
    vecs[2] = '{mask: 4'b0011, n: 3'd2, order: 8'b00_00_01_00};
    vecs[3] = '{mask: 4'b1001, n: 3'd2, order: 8'b00_00_00_11};
    vecs[4] = '{mask: 4'b0001, n: 3'd1, order: 8'b00_00_00_00};
    vecs[5] = '{mask: 4'b0110, n: 3'd2, order: 8'b00_00_10_01};

    do_reset();
    #1;
    check("reset tvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset tready", 64'(s_axis_tready), 64'd0);
    check("reset tdata", 64'(m_axis_tdata), 64'd0);
    check("reset tkeep", 64'(m_axis_tkeep), 64'd0);
    check("reset tlast", 64'(m_axis_tlast), 64'd0);
    check("reset tid", 64'(m_axis_tid), 64'd0);
    check("reset constant", 64'(m_constant), 64'd0);
    check("reset busy", 64'(status_busy), 64'd0);
    check("reset grant", 64'(status_grant), 64'd0);
    @(negedge aclk);

    for (int v = 0; v < 6; v++) begin
      obs_q.delete();
      for (int r = 0; r < N; r++)
        if (vecs[v].mask[r]) push_pkt(r, 1, DW'(v * 16 + r));
      run_until_obs(int'(vecs[v].n), 40, "table");
      drain(40, "table");
      check("table count", 64'(obs_q.size()), 64'(vecs[v].n));
      for (int i = 0; i < int'(vecs[v].n) && i < obs_q.size(); i++)
        check("table order", 64'(obs_q[i].tid), 64'(vecs[v].order[2*i +: 2]));
    end

    // Three-beat packet from requester 1 with constant 5.
    do_reset();
    @(negedge aclk);
    set_const(1, 32'd5);
    for (int i = 0; i < 3; i++) begin
      beat_t b;
      b.data = 64'h1;
      b.keep = '1;
      b.last = (i == 2);
      src_q[1].push_back(b);
    end
    run_until_obs(3, 20, "pkt3");
    drain(20, "pkt3");
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      check("pkt3 tid", 64'(obs_q[i].tid), 64'd1);
      check("pkt3 const", 64'(obs_q[i].cst), 64'd5);
      check("pkt3 data", 64'(obs_q[i].data), 64'h1);
      check("pkt3 last", 64'(obs_q[i].last), 64'(i == 2));
      if (i > 0) check("pkt3 spacing", 64'(obs_q[i].cyc - obs_q[i-1].cyc), 64'd1);
    end

    // All requesters busy with two-beat packets: order 0,1,2,3,0 and one bubble between packets.
    do_reset();
    @(negedge aclk);
    for (int r = 0; r < N; r++) push_pkt(r, 2, DW'(r * 256));
    push_pkt(0, 2, DW'(64'h900));
    run_until_obs(10, 40, "rr");
    begin
      int exp_order[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
        check("rr tid", 64'(obs_q[i].tid), 64'(exp_order[i]));
        if (i > 0)
          check("rr gap", 64'(obs_q[i].cyc - obs_q[i-1].cyc), obs_q[i-1].last ? 64'd2 : 64'd1);
      end
    end
    drain(40, "rr");

    // Output backpressure 1,0,0,1 inside a four-beat packet.
    do_reset();
    @(negedge aclk);
    push_pkt(0, 4, DW'(64'h100));
    tick();
    begin
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        m_axis_tready = pat[i];
        tick();
      end
    end
    m_axis_tready = 1'b1;
    run_until_obs(4, 20, "stall");
    drain(20, "stall");
    check("stall count", 64'(obs_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      check("stall data", 64'(obs_q[i].data), 64'h100 + 64'(i));

    // Constant changes mid-packet: packet keeps 7, the next packet picks up 9.
    do_reset();
    @(negedge aclk);
    set_const(2, 32'd7);
    push_pkt(2, 3, DW'(64'h200));
    push_pkt(2, 2, DW'(64'h300));
    tick();
    tick();
    set_const(2, 32'd9);
    run_until_obs(5, 20, "const");
    begin
      int exp_c[5] = '{7, 7, 7, 9, 9};
      for (int i = 0; i < 5 && i < obs_q.size(); i++)
        check("const value", 64'(obs_q[i].cst), 64'(exp_c[i]));
    end
    drain(20, "const");

    // Enable drops mid-packet of requester 0 while requester 3 waits.
    do_reset();
    @(negedge aclk);
    push_pkt(0, 3, DW'(64'h400));
    push_pkt(3, 1, DW'(64'h500));
    tick();
    tick();
    ctrl_enable = 1'b0;
    repeat (8) tick();
    check("enable pkt0 beats", 64'(obs_q.size()), 64'd3);
    for (int i = 0; i < obs_q.size(); i++)
      check("enable no grant3", 64'(obs_q[i].tid), 64'd0);
    check("enable idle", 64'(status_busy), 64'd0);
    ctrl_enable = 1'b1;
    run_until_obs(4, 10, "enable");
    if (obs_q.size() >= 4) check("enable grant3", 64'(obs_q[3].tid), 64'd3);
    drain(20, "enable");

    // Asynchronous reset mid-packet, then requester 0 must regain first priority.
    do_reset();
    @(negedge aclk);
    push_pkt(2, 1, DW'(64'h600));
    run_until_obs(1, 10, "prerst");
    drain(10, "prerst");
    obs_q.delete();
    push_pkt(0, 4, DW'(64'h700));
    tick();
    tick();
    tick();
    drive();
    #2 areset = 1'b1;
    #1;
    check("async tvalid", 64'(m_axis_tvalid), 64'd0);
    check("async tready", 64'(s_axis_tready), 64'd0);
    check("async busy", 64'(status_busy), 64'd0);
    for (int r = 0; r < N; r++) src_q[r].delete();
    obs_q.delete();
    model_reset();
    drive();
    @(negedge aclk);
    areset = 1'b0;
    push_pkt(3, 1, DW'(64'h800));
    push_pkt(0, 1, DW'(64'h810));
    run_until_obs(2, 20, "postrst");
    if (obs_q.size() >= 2) begin
      check("postrst first", 64'(obs_q[0].tid), 64'd0);
      check("postrst second", 64'(obs_q[1].tid), 64'd3);
    end
    drain(20, "postrst");

    // Randomized traffic, gating, backpressure, enable and constant changes.
    do_reset();
    @(negedge aclk);
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N; r++) begin
        if (src_q[r].size() == 0 && $urandom_range(3) == 0)
          push_pkt(r, int'($urandom_range(4, 1)), {$urandom, $urandom});
        gate[r] = ($urandom_range(7) != 0);
        if ($urandom_range(63) == 0) set_const(r, $urandom);
      end
      m_axis_tready = ($urandom_range(3) != 0);
      ctrl_enable   = ($urandom_range(19) != 0);
      tick();
    end
    drain(400, "random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
